light_step_sequencer: RTL and testbench

- Upstream stage of the per-line light decoders.
- Generates the 6-bit pattern-step index `sel` (0..MAX_STEP) that every line decoder consumes combinationally.
- Divides the system clock into a step rate and advances `sel` once per step.
- Supports run/hold/stop control, loop or one-shot sweeps, and direct loading of a step.

---
 rtl/light_step_sequencer.sv | 79 +++++++
 tb/tb_light_step_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/light_step_sequencer.sv
// light_step_sequencer: divides clk into steps and sweeps sel 0..MAX_STEP with run/hold/stop, one-shot and load.
// Optional macro LIGHT_SEQ_BOUNCE_EN: looping sweeps reverse at the ends instead of wrapping.
module light_step_sequencer #(
    parameter int TICK_DIV = 25000000,
    parameter int MAX_STEP = 59,
    parameter int SEL_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             one_shot,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             step_tick,
    output logic             wrap,
    output logic             done
);
    localparam int PW = $clog2(TICK_DIV + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_t;
    state_t state, nxt;
    logic [PW-1:0] presc;
    logic ev, at_max, nwrap;
    logic [SEL_W-1:0] ld, nsel;
`ifdef LIGHT_SEQ_BOUNCE_EN
    logic dir, ndir, bnc;
    always_comb begin
        bnc  = !one_shot;
        nsel = !bnc ? (at_max ? '0 : sel + 1'b1)
             : dir  ? (at_max ? SEL_W'(MAX_STEP - 1) : sel + 1'b1)
             :        (sel == '0 ? SEL_W'(1) : sel - 1'b1);
        nwrap = bnc ? (dir ? at_max : sel == '0) : at_max;
        ndir  = bnc ? (dir ? !at_max : sel == '0) : 1'b1;
    end
`else
    always_comb begin
        nsel  = at_max ? '0 : sel + 1'b1;
        nwrap = at_max;
    end
`endif
    // load outranks a coincident step, so a step is only an event when no load is pending
    always_comb begin
        at_max = sel == SEL_W'(MAX_STEP);
        ev     = state == RUN && !stop && !load && presc == PW'(TICK_DIV - 1);
        ld     = load_val > SEL_W'(MAX_STEP) ? SEL_W'(MAX_STEP) : load_val;
        nxt    = state == IDLE ? ((start && !stop) ? RUN : IDLE)
               : state == RUN  ? (stop ? HOLD : (ev && at_max && one_shot) ? IDLE : RUN)
               : state == HOLD ? (stop ? IDLE : start ? RUN : HOLD)
               : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            presc     <= '0;
            busy      <= 1'b0;
            step_tick <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
`ifdef LIGHT_SEQ_BOUNCE_EN
            dir       <= 1'b1;
`endif
        end else begin
            state     <= nxt;
            busy      <= nxt != IDLE;
            step_tick <= ev;
            wrap      <= ev && nwrap;
            done      <= ev && at_max && one_shot;
            presc     <= (load || ev || nxt == IDLE) ? '0 : (state == RUN && !stop) ? presc + 1'b1 : presc;
            sel       <= load ? ld : ev ? nsel
                       : ((state == HOLD && stop) || state == state_t'(2'b11)) ? '0 : sel;
`ifdef LIGHT_SEQ_BOUNCE_EN
            dir       <= (load || nxt == IDLE) ? 1'b1 : ev ? ndir : dir;
`endif
        end
    end
endmodule

// File: tb/tb_light_step_sequencer.sv
// tb_light_step_sequencer: directed scoreboard bench; u selects the TICK_DIV=4 (0) or TICK_DIV=1 (1) instance.
module tb_light_step_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, one_shot = 1'b0, load = 1'b0, u = 1'b0;
    logic [5:0] load_val = '0;
    logic [5:0] sel, sel1;
    logic busy, step_tick, wrap, done, busy1, tick1, wrap1, done1;
    logic [9:0] q[$];
    int checks = 0, errors = 0;
    string tag = "reset";

    always #5 clk = ~clk;

    light_step_sequencer #(.TICK_DIV(4), .MAX_STEP(59), .SEL_W(6)) d4 (
        .clk(clk), .rst_n(rst_n), .start(start & ~u), .stop(stop & ~u), .one_shot(one_shot),
        .load(load & ~u), .load_val(load_val), .sel(sel), .busy(busy),
        .step_tick(step_tick), .wrap(wrap), .done(done));

    light_step_sequencer #(.TICK_DIV(1), .MAX_STEP(59), .SEL_W(6)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start & u), .stop(stop & u), .one_shot(one_shot),
        .load(load & u), .load_val(load_val), .sel(sel1), .busy(busy1),
        .step_tick(tick1), .wrap(wrap1), .done(done1));

    task automatic cmp();
        logic [9:0] e, o;
        e = q.pop_front();
        o = u ? {sel1, busy1, tick1, wrap1, done1} : {sel, busy, step_tick, wrap, done};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed sel=%0d busy/tick/wrap/done=%b expected sel=%0d busy/tick/wrap/done=%b",
                   tag, o[9:4], o[3:0], e[9:4], e[3:0]);
        end
    endtask

    task automatic step(input logic s, p, l, input logic [5:0] lv,
                        input logic [5:0] es, input logic eb, et, ew, ed);
        start = s; stop = p; load = l; load_val = lv;
        q.push_back({es, eb, et, ew, ed});
        @(posedge clk);
        #1;
        cmp();
        start = 1'b0; stop = 1'b0; load = 1'b0;
    endtask

    task automatic nop(input logic [5:0] es, input logic eb);
        step(0, 0, 0, 0, es, eb, 0, 0, 0);
    endtask

    initial begin
        #3;
        q.push_back('0);
        cmp();
        @(negedge clk) rst_n = 1'b1;
        tag = "first_step";
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) nop(0, 1);
        step(0, 0, 0, 0, 1, 1, 1, 0, 0);
        tag = "loop_wrap";
        for (int k = 2; k <= 60; k++) begin
            repeat (3) nop(6'(k - 1), 1);
            step(0, 0, 0, 0, 6'(k % 60), 1, 1, k == 60, 0);
        end
        tag = "hold_resume";
        nop(0, 1);
        nop(0, 1);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        repeat (9) nop(0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(0, 1);
        step(0, 0, 0, 0, 1, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tag = "one_shot";
        step(0, 0, 1, 58, 58, 0, 0, 0, 0);
        one_shot = 1'b1;
        step(1, 0, 0, 0, 58, 1, 0, 0, 0);
        repeat (3) nop(58, 1);
        step(0, 0, 0, 0, 59, 1, 1, 0, 0);
        repeat (3) nop(59, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1);
        repeat (3) nop(0, 0);
        one_shot = 1'b0;
        tag = "clamp";
        step(0, 0, 1, 63, 59, 0, 0, 0, 0);
        tag = "start_stop_idle";
        step(1, 1, 0, 0, 59, 0, 0, 0, 0);
        nop(59, 0);
        tag = "load_on_step";
        step(1, 0, 0, 0, 59, 1, 0, 0, 0);
        repeat (3) nop(59, 1);
        step(0, 0, 1, 10, 10, 1, 0, 0, 0);
        repeat (3) nop(10, 1);
        step(0, 0, 0, 0, 11, 1, 1, 0, 0);
        tag = "load_hold_stop";
        step(0, 1, 0, 0, 11, 1, 0, 0, 0);
        step(0, 1, 1, 20, 20, 0, 0, 0, 0);
        tag = "async_reset";
        step(0, 0, 1, 29, 29, 0, 0, 0, 0);
        step(1, 0, 0, 0, 29, 1, 0, 0, 0);
        repeat (3) nop(29, 1);
        step(0, 0, 0, 0, 30, 1, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        q.push_back('0);
        cmp();
        @(negedge clk) rst_n = 1'b1;
        tag = "after_reset";
        repeat (5) nop(0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) nop(0, 1);
        step(0, 0, 0, 0, 1, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tag = "div1_ends";
        u = 1'b1;
        step(0, 0, 1, 58, 58, 0, 0, 0, 0);
        step(1, 0, 0, 0, 58, 1, 0, 0, 0);
        step(0, 0, 0, 0, 59, 1, 1, 0, 0);
`ifdef LIGHT_SEQ_BOUNCE_EN
        step(0, 0, 0, 0, 58, 1, 1, 1, 0);
        for (int v = 57; v >= 0; v--) step(0, 0, 0, 0, 6'(v), 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 2, 1, 1, 0, 0);
        step(0, 1, 0, 0, 2, 1, 0, 0, 0);
`else
        step(0, 0, 0, 0, 0, 1, 1, 1, 0);
        for (int v = 1; v <= 3; v++) step(0, 0, 0, 0, 6'(v), 1, 1, 0, 0);
        step(0, 1, 0, 0, 3, 1, 0, 0, 0);
`endif
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        u = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
